// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [2:0] {
        StRun,
        StLdStall,
        StIntFlush,
        StIntVec,
        StInIsr
    } state_e;

    localparam int unsigned DefRegAw       = 4;
    localparam int unsigned DefPcW         = 16;
    localparam int unsigned DefLoadStall   = 1;
    localparam int unsigned DefIntFlushCyc = 2;
    localparam int unsigned DefCntW        = 8;

    // Width of the shared stall/flush cycle counter (cycle counts are 1..7).
    localparam int unsigned CycW = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = DefRegAw,
    parameter int unsigned PC_W   = DefPcW,
    parameter int unsigned CNT_W  = DefCntW
);
    logic              int_req_i;
    logic              int_en_i;
    logic              eret_i;
    logic              memread_i;
    logic              memtoreg_i;
    logic [REG_AW-1:0] regdst_i;
    logic [REG_AW-1:0] regsrc1_i;
    logic [REG_AW-1:0] regsrc2_i;
    logic              src1_used_i;
    logic              src2_used_i;
    logic              isjump_i;
    logic              isbranch_i;
    logic              ifbranch_i;
    logic              prediction_i;
    logic [PC_W-1:0]   epc_i;

    logic              stall_o;
    logic              bubble_o;
    logic              flush_if_o;
    logic              flush_id_o;
    logic              flush_ex_o;
    logic              jr_o;
    logic              prewrong_o;
    logic              precorrc_o;
    logic              int_vec_o;
    logic              eret_o;
    logic              int_active_o;
    logic [PC_W-1:0]   epc_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    modport master (
        output int_req_i, int_en_i, eret_i, memread_i, memtoreg_i, regdst_i,
               regsrc1_i, regsrc2_i, src1_used_i, src2_used_i, isjump_i,
               isbranch_i, ifbranch_i, prediction_i, epc_i,
        input  stall_o, bubble_o, flush_if_o, flush_id_o, flush_ex_o, jr_o,
               prewrong_o, precorrc_o, int_vec_o, eret_o, int_active_o,
               epc_o, miss_cnt_o
    );

    modport slave (
        input  int_req_i, int_en_i, eret_i, memread_i, memtoreg_i, regdst_i,
               regsrc1_i, regsrc2_i, src1_used_i, src2_used_i, isjump_i,
               isbranch_i, ifbranch_i, prediction_i, epc_i,
        output stall_o, bubble_o, flush_if_o, flush_id_o, flush_ex_o, jr_o,
               prewrong_o, precorrc_o, int_vec_o, eret_o, int_active_o,
               epc_o, miss_cnt_o
    );

endinterface

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter used for branch-mispredict statistics.
module hazard_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next value: step by one unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, interrupt entry/return
// sequencing and branch/jump resolution signalling.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW        = DefRegAw,
    parameter int unsigned PC_W          = DefPcW,
    parameter int unsigned LOAD_STALL    = DefLoadStall,
    parameter int unsigned INT_FLUSH_CYC = DefIntFlushCyc,
    parameter int unsigned CNT_W         = DefCntW
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_if.slave bus
);
    localparam logic [CycW-1:0] LdInit    = CycW'(LOAD_STALL - 1);
    localparam logic [CycW-1:0] FlushInit = CycW'(INT_FLUSH_CYC - 1);

    state_e            state_q, state_d;
    logic [CycW-1:0]   cnt_q, cnt_d;
    // Remembers that the current load stall was entered from the ISR.
    logic              from_isr_q, from_isr_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [CNT_W-1:0]  miss_cnt;

    logic [REG_AW-1:0] dst, src1, src2;
    logic              hazard, int_active, take_int, eret_take;
    logic              stall, bubble, flush_if, flush_id, flush_ex;
    logic              jr, prewrong, precorrc, int_vec, eret;

    assign dst  = bus.regdst_i;
    assign src1 = bus.regsrc1_i;
    assign src2 = bus.regsrc2_i;

    assign hazard = bus.memread_i & bus.memtoreg_i &
                    ((bus.src1_used_i & (src1 == dst)) | (bus.src2_used_i & (src2 == dst)));

    assign int_active = (state_q == StIntVec) | (state_q == StInIsr) |
                        ((state_q == StLdStall) & from_isr_q);

    // Interrupts are masked whenever a handler is active (no nesting).
    assign take_int = bus.int_req_i & bus.int_en_i & ~int_active &
                      ((state_q == StRun) | (state_q == StLdStall));

    assign eret_take = (state_q == StInIsr) & bus.eret_i;

    // State, cycle counter, ISR-origin flag and EPC registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            from_isr_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_isr_q <= from_isr_d;
            epc_q      <= epc_d;
        end
    end

    // Next-state logic: interrupt entry first, then per-state sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        from_isr_d = from_isr_q;
        epc_d      = epc_q;
        if (take_int) begin
            epc_d      = bus.epc_i;
            cnt_d      = FlushInit;
            from_isr_d = 1'b0;
            state_d    = StIntFlush;
        end else begin
            unique case (state_q)
                StRun, StInIsr: begin
                    if (eret_take) begin
                        state_d = StRun;
                    end else if (hazard) begin
                        cnt_d      = LdInit;
                        from_isr_d = (state_q == StInIsr);
                        if (LOAD_STALL > 1) begin
                            state_d = StLdStall;
                        end
                    end
                end
                StLdStall: begin
                    cnt_d = cnt_q - CycW'(1);
                    // The first stall cycle was spent in RUN/IN_ISR.
                    if ((cnt_q == CycW'(1)) || (cnt_q == '0)) begin
                        state_d = from_isr_q ? StInIsr : StRun;
                    end
                end
                StIntFlush: begin
                    if (cnt_q == '0) begin
                        state_d = StIntVec;
                    end else begin
                        cnt_d = cnt_q - CycW'(1);
                    end
                end
                StIntVec: begin
                    state_d = StInIsr;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // Output decode; priority is interrupt > eret > load-use > branch/jr.
    always_comb begin
        stall    = 1'b0;
        bubble   = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        jr       = 1'b0;
        prewrong = 1'b0;
        precorrc = 1'b0;
        int_vec  = 1'b0;
        eret     = 1'b0;
        if (!RST) begin
            unique case (state_q)
                StRun, StInIsr: begin
                    if (take_int) begin
                        // Nothing issues while the interrupt is being taken.
                    end else if (eret_take) begin
                        eret     = 1'b1;
                        flush_if = 1'b1;
                    end else if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end else begin
                        jr       = bus.isjump_i;
                        prewrong = bus.isbranch_i & (bus.prediction_i ^ bus.ifbranch_i);
                        precorrc = bus.isbranch_i & (bus.prediction_i ~^ bus.ifbranch_i);
                        flush_if = prewrong;
                    end
                end
                StLdStall: begin
                    stall  = ~take_int;
                    bubble = ~take_int;
                end
                StIntFlush: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end
                StIntVec: begin
                    int_vec = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    hazard_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk (CLK),
        .rst (RST),
        .inc (prewrong),
        .cnt (miss_cnt)
    );

    assign bus.stall_o      = stall;
    assign bus.bubble_o     = bubble;
    assign bus.flush_if_o   = flush_if;
    assign bus.flush_id_o   = flush_id;
    assign bus.flush_ex_o   = flush_ex;
    assign bus.jr_o         = jr;
    assign bus.prewrong_o   = prewrong;
    assign bus.precorrc_o   = precorrc;
    assign bus.int_vec_o    = int_vec;
    assign bus.eret_o       = eret;
    assign bus.int_active_o = int_active & ~RST;
    assign bus.epc_o        = epc_q;
    assign bus.miss_cnt_o   = miss_cnt;

endmodule
